// File: rtl/acc_uart_tx.sv
// acc_uart_tx: transmits a DB-bit accumulator word as DB/8 back-to-back
// 8N1 UART frames, least-significant byte first, LSB first within each byte.
//
// Ports
//   clk     : single clock, all state updates on its rising edge
//   reset   : asynchronous, active-high reset
//   Entrada : word to transmit, captured only when Start is accepted in IDLE
//   Start   : transmit request, level-sampled each rising edge
//   Tx      : registered serial line, idle high
//   Busy    : registered, high while the FSM is outside IDLE
//   Done    : one-cycle pulse in the first IDLE cycle after the last stop bit
module acc_uart_tx #(
  parameter int DB           = 16,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DB-1:0] Entrada,
  input  logic          Start,
  output logic          Tx,
  output logic          Busy,
  output logic          Done
);

  localparam int NBYTES = DB / 8;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   baud, baud_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [BW-1:0]   byte_idx, byte_idx_d;
  logic [DB-1:0]   shadow, shadow_d;
  logic            tx_d, busy_d, done_d;
  logic            baud_end;
  logic [7:0]      cur_byte;

  always_comb begin
    state_d    = state;
    baud_d     = baud;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    shadow_d   = shadow;
    done_d     = 1'b0;
    tx_d       = 1'b1;
    baud_end   = (baud == BAUD_LAST);
    // The shadow is shifted down one byte per completed byte, so the byte
    // being sent always sits in the low 8 bits.
    cur_byte   = shadow[7:0];

    // Tx follows the current state, so it lags the state register by one
    // cycle: it falls on the edge after the one that accepted Start.
    case (state)
      IDLE:      tx_d = 1'b1;
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = cur_byte[bit_idx];
      STOP_BIT:  tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase

    case (state)
      IDLE: begin
        if (Start) begin
          shadow_d   = Entrada;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          baud_d     = '0;
          state_d    = START_BIT;
        end
      end
      START_BIT: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx == BYTE_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx + 1'b1;
            shadow_d   = shadow >> 8;
            bit_idx_d  = '0;
            state_d    = START_BIT;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy tracks the state register exactly, so it is derived from the
    // next state rather than the current one.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      Tx       <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      shadow   <= shadow_d;
      Tx       <= tx_d;
      Busy     <= busy_d;
      Done     <= done_d;
    end
  end

endmodule

// File: tb/tb_acc_uart_tx.sv
// Testbench for acc_uart_tx with DB=16, CLKS_PER_BIT=4.
// Expected line activity comes from a frame model: bit j of the serial
// stream is start/data/stop of byte j/10, each bit lasting 4 cycles.
module tb_acc_uart_tx;

  localparam int CPB  = 4;
  localparam int DBW  = 16;
  localparam int FLEN = 10 * CPB * (DBW / 8);

  logic            clk;
  logic            reset;
  logic [DBW-1:0]  Entrada;
  logic            Start;
  logic            Tx;
  logic            Busy;
  logic            Done;

  int checks = 0;
  int errors = 0;

  acc_uart_tx #(
    .DB           (DBW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Entrada (Entrada),
    .Start   (Start),
    .Tx      (Tx),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial stream bit j (0..19) for word v: per byte 0, d0..d7, 1.
  function automatic logic frame_bit(input logic [DBW-1:0] v, input int j);
    int k;
    int p;
    k = j / 10;
    p = j % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return v[8 * k + p - 1];
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    Start   = 1'b0;
    Entrada = '0;
    #2;
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", Tx); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    tick();
    tick();
    #3;
    reset = 1'b0;
  endtask

  // One full transfer of v. At cycle poke_n, Start is driven to poke_start
  // and Entrada to poke_val; with scramble set Entrada is randomised every
  // other cycle. Neither may disturb the frame.
  task automatic run_frame(input logic [DBW-1:0] v, input int poke_n,
                           input logic poke_start, input logic [DBW-1:0] poke_val,
                           input bit scramble, input string tag);
    int dones;
    logic exp_tx;
    Entrada = v;
    Start   = 1'b1;
    tick();
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL %s accept_busy got %b want 1", tag, Busy); end
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL %s accept_tx got %b want 1", tag, Tx); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL %s accept_done got %b want 0", tag, Done); end
    dones = 0;
    for (int n = 1; n <= FLEN; n++) begin
      Start = (n == poke_n) ? poke_start : 1'b0;
      if (n == poke_n) Entrada = poke_val;
      else if (scramble) Entrada = DBW'($urandom);
      tick();
      exp_tx = frame_bit(v, (n - 1) / CPB);
      checks++;
      if (Tx !== exp_tx) begin
        errors++; $display("FAIL %s tx cycle %0d got %b want %b", tag, n, Tx, exp_tx);
      end
      checks++;
      if (Busy !== (n < FLEN)) begin
        errors++; $display("FAIL %s busy cycle %0d got %b want %b", tag, n, Busy, n < FLEN);
      end
      checks++;
      if (Done !== (n == FLEN)) begin
        errors++; $display("FAIL %s done cycle %0d got %b want %b", tag, n, Done, n == FLEN);
      end
      if (Done === 1'b1) dones++;
    end
    Start = 1'b0;
    tick();
    checks++;
    if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after got tx%b busy%b done%b want tx1 busy0 done0", tag, Tx, Busy, Done);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, dones); end
  endtask

  task automatic test_basic();
    run_frame(16'hA55A, 0, 1'b0, 16'h0000, 1'b0, "a55a");
  endtask

  task automatic test_start_ignored();
    run_frame(16'hA55A, 30, 1'b1, 16'hFFFF, 1'b0, "restart_ignored");
  endtask

  task automatic test_input_change();
    run_frame(16'h1234, 1, 1'b0, 16'h0000, 1'b0, "entrada_change");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame(DBW'($urandom), int'($urandom_range(1, FLEN - 1)), 1'($urandom),
                DBW'($urandom), 1'b1, "random");
    end
  endtask

  task automatic test_reset_midframe();
    Entrada = 16'hA55A;
    Start   = 1'b1;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 44; n++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (Tx !== 1'b1) begin errors++; $display("FAIL abort_tx got %b want 1", Tx); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", Busy); end
    Start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
        errors++; $display("FAIL abort_hold cycle %0d got tx%b busy%b done%b want tx1 busy0 done0", n, Tx, Busy, Done);
      end
    end
    #3;
    reset = 1'b0;
    Start = 1'b0;
    run_frame(16'h00FF, 0, 1'b0, 16'h0000, 1'b0, "after_abort");
  endtask

  // Start held high: each transfer is 80 busy cycles plus the one IDLE
  // cycle (carrying Done) whose closing edge accepts the next transfer.
  task automatic test_back_to_back();
    int r;
    logic exp_tx, exp_busy, exp_done;
    Entrada = 16'h0001;
    Start   = 1'b1;
    tick();
    for (int t = 1; t <= 243; t++) begin
      Start = (t <= 200);
      tick();
      if (t == 243) begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
        r = t % (FLEN + 1);
        if (r == 0) begin
          exp_tx = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
        end else begin
          exp_tx   = frame_bit(16'h0001, (r - 1) / CPB);
          exp_busy = (r < FLEN);
          exp_done = (r == FLEN);
        end
      end
      checks++;
      if (Tx !== exp_tx) begin errors++; $display("FAIL b2b tx t=%0d got %b want %b", t, Tx, exp_tx); end
      checks++;
      if (Busy !== exp_busy) begin errors++; $display("FAIL b2b busy t=%0d got %b want %b", t, Busy, exp_busy); end
      checks++;
      if (Done !== exp_done) begin errors++; $display("FAIL b2b done t=%0d got %b want %b", t, Done, exp_done); end
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_input_change();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
